// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Bank of NCHAN independent event counters for the debug unit. Each channel
//   has a step enable, a synchronous clear, wrap or saturate behaviour on
//   overflow and a sticky overflow flag. A global freeze masks all steps, and
//   a snapshot copies every live count into shadow registers in one edge.
//   Shadows are read one at a time through a registered read port.
//
// Ports
//   i_clk        clock, all state updates on posedge
//   i_rst        asynchronous active-high reset
//   i_step       per-channel increment request
//   i_clr        per-channel synchronous clear of count and overflow flag
//   i_freeze     masks all i_step bits (clears still honoured)
//   i_snap       copy all live counts into the shadow registers
//   i_rd_addr    shadow channel to read
//   o_rd_data    registered shadow[i_rd_addr], 0 for addresses >= NCHAN
//   o_ovf        sticky per-channel overflow flags (live)
//   o_snap_valid set once any snapshot has been taken since reset
module perf_counter_bank #(
  parameter int NBITS     = 32,
  parameter int NCHAN     = 4,
  parameter int ADDR_BITS = 2,
  parameter int SATURATE  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NCHAN-1:0]     i_step,
  input  logic [NCHAN-1:0]     i_clr,
  input  logic                 i_freeze,
  input  logic                 i_snap,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [NBITS-1:0]     o_rd_data,
  output logic [NCHAN-1:0]     o_ovf,
  output logic                 o_snap_valid
);

  localparam logic [NBITS-1:0] ALL_ONES = {NBITS{1'b1}};

  logic [NBITS-1:0] count  [NCHAN];
  logic [NBITS-1:0] shadow [NCHAN];
  logic [NCHAN-1:0] ovf;
  logic [NBITS-1:0] rd_mux;

  // Shadow capture uses the count value from before this edge's update, so a
  // snap coinciding with a clear or step records the pre-update value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NCHAN; k++) begin
        count[k]  <= '0;
        shadow[k] <= '0;
      end
      ovf          <= '0;
      o_snap_valid <= 1'b0;
    end else begin
      for (int k = 0; k < NCHAN; k++) begin
        if (i_snap) begin
          shadow[k] <= count[k];
        end
        if (i_clr[k]) begin
          count[k] <= '0;
          ovf[k]   <= 1'b0;
        end else if (!i_freeze && i_step[k]) begin
          if (count[k] != ALL_ONES) begin
            count[k] <= count[k] + 1'b1;
          end else begin
            ovf[k] <= 1'b1;
            if (SATURATE == 0) begin
              count[k] <= '0;
            end
          end
        end
      end
      if (i_snap) begin
        o_snap_valid <= 1'b1;
      end
    end
  end

  // Address decode by compare so unpopulated addresses read as zero without
  // indexing past the shadow array.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (ADDR_BITS'(k) == i_rd_addr) begin
        rd_mux = shadow[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= rd_mux;
    end
  end

  assign o_ovf = ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank. Three instances share the stimulus:
//   u_main : NBITS=32, NCHAN=4, wrap
//   u_wrap : NBITS=4,  NCHAN=3, wrap (also covers out-of-range read)
//   u_sat  : NBITS=4,  NCHAN=3, saturate
module tb_perf_counter_bank;

  logic       clk;
  logic       rst;
  logic [3:0] step;
  logic [3:0] clr;
  logic       freeze;
  logic       snap;
  logic [1:0] rd_addr;

  logic [31:0] rd_main;
  logic [3:0]  ovf_main;
  logic        sv_main;
  logic [3:0]  rd_wrap;
  logic [2:0]  ovf_wrap;
  logic        sv_wrap;
  logic [3:0]  rd_sat;
  logic [2:0]  ovf_sat;
  logic        sv_sat;

  int errors;
  int checks;

  perf_counter_bank #(.NBITS(32), .NCHAN(4), .ADDR_BITS(2), .SATURATE(0)) u_main (
    .i_clk(clk), .i_rst(rst), .i_step(step), .i_clr(clr), .i_freeze(freeze),
    .i_snap(snap), .i_rd_addr(rd_addr), .o_rd_data(rd_main), .o_ovf(ovf_main),
    .o_snap_valid(sv_main)
  );

  perf_counter_bank #(.NBITS(4), .NCHAN(3), .ADDR_BITS(2), .SATURATE(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_step(step[2:0]), .i_clr(clr[2:0]), .i_freeze(freeze),
    .i_snap(snap), .i_rd_addr(rd_addr), .o_rd_data(rd_wrap), .o_ovf(ovf_wrap),
    .o_snap_valid(sv_wrap)
  );

  perf_counter_bank #(.NBITS(4), .NCHAN(3), .ADDR_BITS(2), .SATURATE(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_step(step[2:0]), .i_clr(clr[2:0]), .i_freeze(freeze),
    .i_snap(snap), .i_rd_addr(rd_addr), .o_rd_data(rd_sat), .o_ovf(ovf_sat),
    .o_snap_valid(sv_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    step = '0; clr = '0; freeze = 1'b0; snap = 1'b0; rd_addr = '0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  // snapshot now, then read one address of all instances one cycle later
  task automatic snap_then_addr(input logic [1:0] a);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    rd_addr = a;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_main !== 32'd0 || ovf_main !== 4'd0 || sv_main !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: rd=%0d ovf=%b sv=%b required 0 0 0", rd_main, ovf_main, sv_main);
    end
    step = 4'b1111;
    tick(5);
    snap = 1'b1;             // snap with step active captures pre-step value 5
    tick(1);
    snap = 1'b0;
    rd_addr = 2'd0;
    tick(1);
    checks++;
    if (rd_main !== 32'd5) begin
      errors++;
      $display("FAIL reset_precount: rd=%0d required 5", rd_main);
    end
    checks++;
    if (sv_main !== 1'b1) begin
      errors++;
      $display("FAIL reset_presv: sv=%b required 1", sv_main);
    end
    #2;
    rst = 1'b1;              // mid-cycle, steps still active
    #1;
    checks++;
    if (rd_main !== 32'd0 || ovf_main !== 4'd0 || sv_main !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rd=%0d ovf=%b sv=%b required 0 0 0", rd_main, ovf_main, sv_main);
    end
    tick(2);
    checks++;
    if (rd_main !== 32'd0 || sv_main !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rd=%0d sv=%b required 0 0", rd_main, sv_main);
    end
    step = '0;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_steps_snap();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'd10; exp_rd[1] = 32'd0; exp_rd[2] = 32'd10; exp_rd[3] = 32'd0;
    do_reset();
    step = 4'b0101;
    tick(10);
    step = '0;
    snap = 1'b1;
    rd_addr = 2'd0;
    tick(1);
    snap = 1'b0;
    checks++;
    if (rd_main !== 32'd0) begin
      errors++;
      $display("FAIL snap_latency: rd=%0d required 0 (old shadow)", rd_main);
    end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      tick(1);
      checks++;
      if (rd_main !== exp_rd[a]) begin
        errors++;
        $display("FAIL steps_read%0d: rd=%0d required %0d", a, rd_main, exp_rd[a]);
      end
    end
    checks++;
    if (sv_main !== 1'b1) begin
      errors++;
      $display("FAIL snap_valid: sv=%b required 1", sv_main);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step = 4'b0010;
    tick(17);
    step = '0;
    checks++;
    if (ovf_wrap !== 3'b010) begin
      errors++;
      $display("FAIL wrap_ovf: ovf=%b required 010", ovf_wrap);
    end
    snap_then_addr(2'd1);
    checks++;
    if (rd_wrap !== 4'd1) begin
      errors++;
      $display("FAIL wrap_count: rd=%0d required 1", rd_wrap);
    end
    checks++;
    if (rd_sat !== 4'd15 || ovf_sat !== 3'b010) begin
      errors++;
      $display("FAIL sat_17: rd=%0d ovf=%b required 15 010", rd_sat, ovf_sat);
    end
    clr = 4'b0010;
    tick(1);
    clr = '0;
    checks++;
    if (ovf_wrap !== 3'b000) begin
      errors++;
      $display("FAIL wrap_clr_ovf: ovf=%b required 000", ovf_wrap);
    end
    snap_then_addr(2'd1);
    checks++;
    if (rd_wrap !== 4'd0) begin
      errors++;
      $display("FAIL wrap_clr_count: rd=%0d required 0", rd_wrap);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step = 4'b0100;
    tick(20);
    step = '0;
    snap_then_addr(2'd2);
    checks++;
    if (rd_sat !== 4'd15) begin
      errors++;
      $display("FAIL sat_count: rd=%0d required 15", rd_sat);
    end
    checks++;
    if (ovf_sat !== 3'b100) begin
      errors++;
      $display("FAIL sat_ovf: ovf=%b required 100", ovf_sat);
    end
    checks++;
    if (rd_wrap !== 4'd4 || ovf_wrap !== 3'b100) begin
      errors++;
      $display("FAIL wrap_20: rd=%0d ovf=%b required 4 100", rd_wrap, ovf_wrap);
    end
  endtask

  task automatic test_freeze_clear();
    do_reset();
    step = 4'b0011;
    tick(7);
    freeze = 1'b1;
    step = 4'b1111;
    tick(5);
    freeze = 1'b0;
    step = '0;
    snap_then_addr(2'd0);
    checks++;
    if (rd_main !== 32'd7) begin
      errors++;
      $display("FAIL freeze_ch0: rd=%0d required 7", rd_main);
    end
    rd_addr = 2'd2;
    tick(1);
    checks++;
    if (rd_main !== 32'd0) begin
      errors++;
      $display("FAIL freeze_ch2: rd=%0d required 0", rd_main);
    end
    clr = 4'b0001;
    snap = 1'b1;
    tick(1);
    clr = '0;
    snap = 1'b0;
    rd_addr = 2'd0;
    tick(1);
    checks++;
    if (rd_main !== 32'd7) begin
      errors++;
      $display("FAIL clr_snap_pre: rd=%0d required 7", rd_main);
    end
    snap_then_addr(2'd0);
    checks++;
    if (rd_main !== 32'd0) begin
      errors++;
      $display("FAIL clr_snap_post: rd=%0d required 0", rd_main);
    end
    rd_addr = 2'd1;
    tick(1);
    checks++;
    if (rd_main !== 32'd7) begin
      errors++;
      $display("FAIL clr_independent: rd=%0d required 7", rd_main);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    step = 4'b0111;
    tick(3);
    step = '0;
    snap_then_addr(2'd2);
    checks++;
    if (rd_wrap !== 4'd3) begin
      errors++;
      $display("FAIL oor_inrange: rd=%0d required 3", rd_wrap);
    end
    rd_addr = 2'd3;
    tick(1);
    checks++;
    if (rd_wrap !== 4'd0) begin
      errors++;
      $display("FAIL oor_addr3: rd=%0d required 0", rd_wrap);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step = 4'b0001;
    snap = 1'b1;
    rd_addr = 2'd0;
    tick(3);                 // shadow holds 2 after edge 3, rd shows 1
    checks++;
    if (rd_main !== 32'd1) begin
      errors++;
      $display("FAIL b2b_first: rd=%0d required 1", rd_main);
    end
    tick(1);
    checks++;
    if (rd_main !== 32'd2) begin
      errors++;
      $display("FAIL b2b_second: rd=%0d required 2", rd_main);
    end
    step = '0;
    snap = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    step = '0; clr = '0; freeze = 1'b0; snap = 1'b0; rd_addr = '0;
    test_reset();
    test_steps_snap();
    test_wrap();
    test_saturate();
    test_freeze_clear();
    test_out_of_range();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
